// File: rtl/pkt_buffer_ctrl_pkg.sv
// Shared types and constants for the packet buffer controller:
// write/read FSM state enums and CRC-32 polynomial/residue.
package pkt_buffer_ctrl_pkg;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_COMMIT,
      W_DROP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_STREAM
   } rd_state_e;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   function automatic logic [31:0] bitrev32(
      input logic [31:0] v
   );
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_update.sv
// Reflected CRC-32 step over one received word, LSB first.
// Only built when PKT_BUF_CRC_CHECK_EN is defined.
`ifdef PKT_BUF_CRC_CHECK_EN
module crc32_update
   import pkt_buffer_ctrl_pkg::*;
#(
   parameter int pDATA_WIDTH = 8
)(
   input  logic [31:0]            icrc,
   input  logic [pDATA_WIDTH-1:0] idata,
   output logic [31:0]            ocrc
);

   localparam logic [31:0] POLY_R = bitrev32(CRC_POLY);

   always_comb begin
      logic [31:0] c;
      logic        fb;
      c = icrc;
      for (int i = 0; i < pDATA_WIDTH; i++) begin
         fb = c[0] ^ idata[i];
         c  = c >> 1;
         if (fb) c = c ^ POLY_R;
      end
      ocrc = c;
   end

endmodule
`endif

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO, power-of-two depth.
// Head entry is visible on ohead whenever oempty is low.
module fifo #(
   parameter int pWIDTH = 16,
   parameter int pDEPTH = 64
)(
   input  logic              iclk,
   input  logic              i_rst,
   input  logic              ipush,
   input  logic [pWIDTH-1:0] idata,
   input  logic              ipop,
   output logic [pWIDTH-1:0] ohead,
   output logic              oempty,
   output logic              ofull
);

   localparam int AW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

   logic [pWIDTH-1:0] mem [pDEPTH];
   logic [AW:0]       wp;
   logic [AW:0]       rp;

   assign oempty = (wp == rp);
   assign ofull  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
   assign ohead  = mem[rp[AW-1:0]];

   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (ipush && !ofull) wp <= wp + 1'b1;
         if (ipop && !oempty) rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge iclk) begin
      if (ipush && !ofull) mem[wp[AW-1:0]] <= idata;
   end

endmodule

// File: rtl/sram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data appears one cycle after ire.
module sram #(
   parameter int pWIDTH = 8,
   parameter int pDEPTH = 4096
)(
   input  logic                      iclk,
   input  logic                      iwe,
   input  logic [$clog2(pDEPTH)-1:0] iwaddr,
   input  logic [pWIDTH-1:0]         iwdata,
   input  logic                      ire,
   input  logic [$clog2(pDEPTH)-1:0] iraddr,
   output logic [pWIDTH-1:0]         ordata
);

   logic [pWIDTH-1:0] mem [pDEPTH];

   always_ff @(posedge iclk) begin
      if (iwe) mem[iwaddr] <= iwdata;
      if (ire) ordata <= mem[iraddr];
   end

endmodule

// File: rtl/pkt_buffer_ctrl.sv
// Store-and-forward packet buffer with drop-on-error and length FIFO.
// Build option: PKT_BUF_CRC_CHECK_EN adds an FCS residue check at commit.
module pkt_buffer_ctrl
   import pkt_buffer_ctrl_pkg::*;
#(
   parameter int pDATA_WIDTH = 8,
   parameter int pDEPTH_RAM  = 4096,
   parameter int pLEN_WIDTH  = 16,
   parameter int pDESC_DEPTH = 64,
   parameter int pMAX_LEN    = 1536
)(
   input  logic                   iclk,
   input  logic                   i_rst,
   input  logic                   idv,
   input  logic [pDATA_WIDTH-1:0] irx_d,
   input  logic                   irx_er,
   input  logic                   ird,
   output logic [pDATA_WIDTH-1:0] or_data,
   output logic                   or_dv,
   output logic                   or_last,
   output logic [pLEN_WIDTH-1:0]  olen_pac,
   output logic                   oempty,
   output logic                   ofull,
   output logic [15:0]            odrop_cnt
);

   localparam int AW = $clog2(pDEPTH_RAM);
   localparam logic [AW:0] DEPTH_W =
      (AW+1)'(pDEPTH_RAM);
   localparam logic [pLEN_WIDTH-1:0] MAX_LEN =
      pLEN_WIDTH'(pMAX_LEN);

   wr_state_e wr_state, wr_state_n;
   rd_state_e rd_state, rd_state_n;

   logic [AW:0] wr_spec, wr_spec_n;
   logic [AW:0] wr_cmt, wr_cmt_n;
   logic [AW:0] rd_rel, rd_rel_n;
   logic [AW:0] used, free;
   logic        no_space;

   logic [pLEN_WIDTH-1:0] wr_len, wr_len_n;
   logic [pLEN_WIDTH-1:0] rd_len, rd_len_n;
   logic [pLEN_WIDTH-1:0] rd_cnt, rd_cnt_n;

   logic                  ram_we, ram_re;
   logic [AW-1:0]         raddr;
   logic [pDATA_WIDTH-1:0] ram_q;
   logic                  desc_push, desc_pop;
   logic [pLEN_WIDTH-1:0] desc_head;
   logic                  desc_empty, desc_full;
   logic                  drop_inc;
   logic                  crc_ok;

   // Free space counts speculative words, so a packet that would
   // overrun unreleased data is caught while it is still arriving.
   assign used     = wr_spec - rd_rel;
   assign free     = DEPTH_W - used;
   assign no_space = (free == '0);

   assign oempty   = desc_empty;
   assign ofull    = desc_full;
   assign olen_pac = desc_empty ? '0 : desc_head;
   assign or_data  = or_dv ? ram_q : '0;

`ifdef PKT_BUF_CRC_CHECK_EN
   logic [31:0] crc_q, crc_seed, crc_nx;

   assign crc_seed = (wr_state == W_IDLE) ? CRC_INIT : crc_q;
   assign crc_ok   = (bitrev32(crc_q) == CRC_RESIDUE);

   crc32_update #(
      .pDATA_WIDTH (pDATA_WIDTH)
   ) u_crc (
      .icrc  (crc_seed),
      .idata (irx_d),
      .ocrc  (crc_nx)
   );

   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst)       crc_q <= CRC_INIT;
      else if (ram_we) crc_q <= crc_nx;
   end
`else
   assign crc_ok = 1'b1;
`endif

   always_comb begin
      wr_state_n = wr_state;
      wr_spec_n  = wr_spec;
      wr_cmt_n   = wr_cmt;
      wr_len_n   = wr_len;
      ram_we     = 1'b0;
      desc_push  = 1'b0;
      drop_inc   = 1'b0;
      unique case (wr_state)
         W_IDLE: begin
            if (idv) begin
               if (irx_er || ofull || no_space) begin
                  wr_state_n = W_DROP;
               end else begin
                  ram_we     = 1'b1;
                  wr_spec_n  = wr_spec + 1'b1;
                  wr_len_n   = pLEN_WIDTH'(1);
                  wr_state_n = W_DATA;
               end
            end
         end
         W_DATA: begin
            if (!idv) begin
               wr_state_n = W_COMMIT;
            end else if (irx_er || wr_len == MAX_LEN ||
                         no_space) begin
               wr_spec_n  = wr_cmt;
               wr_state_n = W_DROP;
            end else begin
               ram_we    = 1'b1;
               wr_spec_n = wr_spec + 1'b1;
               wr_len_n  = wr_len + 1'b1;
            end
         end
         W_COMMIT: begin
            wr_state_n = W_IDLE;
            if (crc_ok) begin
               desc_push = 1'b1;
               wr_cmt_n  = wr_spec;
            end else begin
               wr_spec_n = wr_cmt;
               drop_inc  = 1'b1;
            end
         end
         W_DROP: begin
            if (!idv) begin
               drop_inc   = 1'b1;
               wr_state_n = W_IDLE;
            end
         end
      endcase
   end

   // rd_cnt is the 1-based index of the word on or_data; the read
   // issued alongside it prefetches the next word.
   always_comb begin
      rd_state_n = rd_state;
      rd_rel_n   = rd_rel;
      rd_len_n   = rd_len;
      rd_cnt_n   = rd_cnt;
      desc_pop   = 1'b0;
      ram_re     = 1'b0;
      or_dv      = 1'b0;
      or_last    = 1'b0;
      raddr      = rd_rel[AW-1:0] + AW'(rd_cnt);
      unique case (rd_state)
         R_IDLE: begin
            rd_cnt_n = '0;
            if (ird && !desc_empty) rd_state_n = R_FETCH;
         end
         R_FETCH: begin
            desc_pop   = 1'b1;
            rd_len_n   = desc_head;
            ram_re     = 1'b1;
            rd_cnt_n   = pLEN_WIDTH'(1);
            rd_state_n = R_STREAM;
         end
         R_STREAM: begin
            or_dv = 1'b1;
            if (rd_cnt == rd_len) begin
               or_last    = 1'b1;
               rd_rel_n   = rd_rel + (AW+1)'(rd_len);
               rd_state_n = R_IDLE;
            end else begin
               ram_re   = 1'b1;
               rd_cnt_n = rd_cnt + 1'b1;
            end
         end
         default: rd_state_n = R_IDLE;
      endcase
   end

   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         wr_state  <= W_IDLE;
         rd_state  <= R_IDLE;
         wr_spec   <= '0;
         wr_cmt    <= '0;
         rd_rel    <= '0;
         wr_len    <= '0;
         rd_len    <= '0;
         rd_cnt    <= '0;
         odrop_cnt <= '0;
      end else begin
         wr_state <= wr_state_n;
         rd_state <= rd_state_n;
         wr_spec  <= wr_spec_n;
         wr_cmt   <= wr_cmt_n;
         rd_rel   <= rd_rel_n;
         wr_len   <= wr_len_n;
         rd_len   <= rd_len_n;
         rd_cnt   <= rd_cnt_n;
         if (drop_inc && odrop_cnt != 16'hFFFF)
            odrop_cnt <= odrop_cnt + 1'b1;
      end
   end

   fifo #(
      .pWIDTH (pLEN_WIDTH),
      .pDEPTH (pDESC_DEPTH)
   ) u_desc (
      .iclk   (iclk),
      .i_rst  (i_rst),
      .ipush  (desc_push),
      .idata  (wr_len),
      .ipop   (desc_pop),
      .ohead  (desc_head),
      .oempty (desc_empty),
      .ofull  (desc_full)
   );

   sram #(
      .pWIDTH (pDATA_WIDTH),
      .pDEPTH (pDEPTH_RAM)
   ) u_ram (
      .iclk   (iclk),
      .iwe    (ram_we),
      .iwaddr (wr_spec[AW-1:0]),
      .iwdata (irx_d),
      .ire    (ram_re),
      .iraddr (raddr),
      .ordata (ram_q)
   );

endmodule

// File: tb/tb_pkt_buffer_ctrl.sv
// Self-checking bench for pkt_buffer_ctrl: random payloads against a
// queue-based packet model (small RAM and descriptor FIFO for boundaries).
module tb_pkt_buffer_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 256;
   localparam int LW    = 16;
   localparam int DESC  = 4;
   localparam int MAXL  = 200;

   logic          iclk = 1'b0;
   logic          i_rst = 1'b1;
   logic          idv = 1'b0;
   logic [DW-1:0] irx_d = '0;
   logic          irx_er = 1'b0;
   logic          ird = 1'b0;
   logic [DW-1:0] or_data;
   logic          or_dv;
   logic          or_last;
   logic [LW-1:0] olen_pac;
   logic          oempty;
   logic          ofull;
   logic [15:0]   odrop_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   int         lq[$];
   int         drops = 0;

   always #5 iclk = ~iclk;

   pkt_buffer_ctrl #(
      .pDATA_WIDTH (DW),
      .pDEPTH_RAM  (DEPTH),
      .pLEN_WIDTH  (LW),
      .pDESC_DEPTH (DESC),
      .pMAX_LEN    (MAXL)
   ) dut (
      .iclk      (iclk),
      .i_rst     (i_rst),
      .idv       (idv),
      .irx_d     (irx_d),
      .irx_er    (irx_er),
      .ird       (ird),
      .or_data   (or_data),
      .or_dv     (or_dv),
      .or_last   (or_last),
      .olen_pac  (olen_pac),
      .oempty    (oempty),
      .ofull     (ofull),
      .odrop_cnt (odrop_cnt)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // Acceptance rule: clean, within length limit, fits in the space
   // not held by committed packets, and a descriptor slot is free.
   function automatic bit will_accept(input int len,
                                      input bit err);
      return !err && len <= MAXL &&
             len <= DEPTH - mq.size() &&
             lq.size() < DESC;
   endfunction

   task automatic send_pkt(input int len, input int err_at,
                           input bit exp_acc);
      logic [7:0] d[$];
      for (int i = 0; i < len; i++) begin
         @(negedge iclk);
         idv    = 1'b1;
         irx_d  = 8'($urandom);
         irx_er = (i == err_at);
         d.push_back(irx_d);
      end
      @(negedge iclk);
      idv    = 1'b0;
      irx_er = 1'b0;
      irx_d  = '0;
      repeat (2) @(negedge iclk);
      if (exp_acc) begin
         lq.push_back(len);
         foreach (d[i]) mq.push_back(d[i]);
      end else begin
         drops++;
      end
      check("drop_cnt", odrop_cnt, drops);
   endtask

   task automatic read_pkt();
      int len;
      int n;
      int bad;
      int last_at;
      logic [7:0] e[$];
      len = lq.pop_front();
      for (int i = 0; i < len; i++) e.push_back(mq.pop_front());
      check("olen_pac", olen_pac, len);
      check("oempty_pre", oempty, 0);
      ird = 1'b1;
      @(negedge iclk);
      n = 1;
      while (!or_dv && n < 8) begin
         @(negedge iclk);
         n++;
      end
      check("rd_latency", n, 2);
      bad = 0;
      last_at = -1;
      for (int i = 0; i < len; i++) begin
         if (!or_dv || or_data !== e[i]) bad++;
         if (or_last && last_at < 0) last_at = i;
         @(negedge iclk);
      end
      ird = 1'b0;
      check("rd_data", bad, 0);
      check("rd_last_at", last_at, len - 1);
      check("rd_dv_end", or_dv, 0);
   endtask

   task automatic reset_checks(input string t);
      check({t, "_or_data"}, or_data, 0);
      check({t, "_or_dv"}, or_dv, 0);
      check({t, "_or_last"}, or_last, 0);
      check({t, "_olen_pac"}, olen_pac, 0);
      check({t, "_oempty"}, oempty, 1);
      check({t, "_ofull"}, ofull, 0);
      check({t, "_odrop_cnt"}, odrop_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      repeat (3) @(negedge iclk);
      reset_checks("rst0");
      i_rst = 1'b0;
      @(negedge iclk);

      send_pkt(40, 9, will_accept(40, 1));
      check("err_oempty", oempty, 1);
      send_pkt(20, -1, will_accept(20, 0));
      read_pkt();

      send_pkt(64, -1, will_accept(64, 0));
      check("p64_oempty", oempty, 0);
      check("p64_len", olen_pac, 64);
      read_pkt();

      send_pkt(MAXL + 1, -1, will_accept(MAXL + 1, 0));
      check("over_oempty", oempty, 1);
      send_pkt(MAXL, -1, will_accept(MAXL, 0));
      read_pkt();

      for (int k = 0; k < DESC; k++) begin
         len = $urandom_range(1, 16);
         send_pkt(len, -1, will_accept(len, 0));
      end
      check("desc_ofull", ofull, 1);
      send_pkt(5, -1, will_accept(5, 0));
      for (int k = 0; k < DESC; k++) read_pkt();
      check("desc_oempty", oempty, 1);
      check("desc_ofull_clr", ofull, 0);

      send_pkt(200, -1, will_accept(200, 0));
      send_pkt(100, -1, will_accept(100, 0));
      read_pkt();

      send_pkt(12, 0, will_accept(12, 1));

      send_pkt(200, -1, will_accept(200, 0));
      for (int k = 0; k < 6; k++) begin
         fork
            read_pkt();
            begin
               repeat (160) @(negedge iclk);
               send_pkt(200, -1, 1'b1);
            end
         join
      end
      read_pkt();
      check("wrap_oempty", oempty, 1);

      send_pkt(30, -1, will_accept(30, 0));
      for (int i = 0; i < 10; i++) begin
         @(negedge iclk);
         idv   = 1'b1;
         irx_d = 8'($urandom);
      end
      #2 i_rst = 1'b1;
      #1 reset_checks("rst_wr");
      @(negedge iclk);
      idv   = 1'b0;
      i_rst = 1'b0;
      mq.delete();
      lq.delete();
      drops = 0;

      send_pkt(30, -1, will_accept(30, 0));
      ird = 1'b1;
      repeat (10) @(negedge iclk);
      ird = 1'b0;
      check("mid_rd_dv", or_dv, 1);
      #2 i_rst = 1'b1;
      #1 reset_checks("rst_rd");
      @(negedge iclk);
      i_rst = 1'b0;
      mq.delete();
      lq.delete();
      drops = 0;
      @(negedge iclk);

      send_pkt(20, -1, will_accept(20, 0));
      read_pkt();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
